// File: rtl/accumulator_bank.sv
// Accumulator buffer below the systolic array output column: captures DEPTH
// partial sums per pass (overwrite or add), then drains them in index order.
module accumulator_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int SAT    = 0,
  localparam int IDX_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              full,
  output logic              ovf,
  output logic              state_dbg
);

  // Handshake: a beat transfers on the rising edge where valid and ready are
  // both high; valid never depends on ready, and a held beat stays unchanged.

  typedef enum logic {S_FILL = 1'b0, S_DRAIN = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]    wr_ptr, rd_ptr;
  logic                accept, drain_hs;
  logic [DATA_W-1:0]   cur_val, acc_val, wr_val;
  logic signed [DATA_W:0] sum;
  logic                sum_ovf;

  assign state_dbg = logic'(state);
  assign accept    = in_valid & in_ready;
  assign drain_hs  = out_valid & out_ready;
  assign cur_val   = mem[wr_ptr];
  assign out_data  = mem[rd_ptr];
  assign out_index = rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FILL;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    full      = 1'b0;
    case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && in_last && (wr_ptr == LAST_IDX)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        full      = 1'b1;
        if (out_ready && (rd_ptr == LAST_IDX)) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
    if (clear) state_nxt = S_FILL;
  end

  // Sign-extended sum; overflow when the two top bits disagree.
  always_comb begin
    sum     = {cur_val[DATA_W-1], cur_val} + {in_data[DATA_W-1], in_data};
    sum_ovf = sum[DATA_W] ^ sum[DATA_W-1];
    acc_val = sum[DATA_W-1:0];
    if (sum_ovf && (SAT != 0)) begin
      acc_val = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                            : {1'b0, {(DATA_W-1){1'b1}}};
    end
    wr_val = in_mode ? acc_val : in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= wr_val;
        wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
        if (in_mode && sum_ovf) ovf <= 1'b1;
      end
      // Drained entries are zeroed so the next tile starts from a clean bank.
      if (drain_hs) begin
        mem[rd_ptr] <= '0;
        if (rd_ptr == LAST_IDX) begin
          rd_ptr <= '0;
          ovf    <= 1'b0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_accumulator_bank.sv
// Scoreboard bench for accumulator_bank: two instances (wrap and saturate)
// share stimulus; a negedge monitor compares drain beats against queues.
module tb_accumulator_bank;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_mode = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready0, out_valid0, full0, ovf0, st0;
  logic [W-1:0]  out_data0;
  logic [1:0]    out_index0;
  logic          in_ready1, out_valid1, full1, ovf1, st1;
  logic [W-1:0]  out_data1;
  logic [1:0]    out_index1;

  logic [33:0]   exp_q0[$];
  logic [33:0]   exp_q1[$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  accumulator_bank #(.DATA_W(W), .DEPTH(4), .SAT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_index(out_index0), .full(full0), .ovf(ovf0), .state_dbg(st0)
  );

  accumulator_bank #(.DATA_W(W), .DEPTH(4), .SAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_index(out_index1), .full(full1), .ovf(ovf1), .state_dbg(st1)
  );

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop on handshake, compare without popping while stalled.
  always @(negedge clk) begin
    if (out_valid0) begin
      if (exp_q0.size() == 0) begin
        if (out_ready) begin
          checks++; errors++;
          $display("FAIL mon0_unexpected: got %h/%h expected none", out_index0, out_data0);
        end
      end else begin
        checks++;
        if ({out_index0, out_data0} !== exp_q0[0]) begin
          errors++;
          $display("FAIL mon0_beat: got %h expected %h", {out_index0, out_data0}, exp_q0[0]);
        end
        if (out_ready) void'(exp_q0.pop_front());
      end
    end
    if (out_valid1) begin
      if (exp_q1.size() == 0) begin
        if (out_ready) begin
          checks++; errors++;
          $display("FAIL mon1_unexpected: got %h/%h expected none", out_index1, out_data1);
        end
      end else begin
        checks++;
        if ({out_index1, out_data1} !== exp_q1[0]) begin
          errors++;
          $display("FAIL mon1_beat: got %h expected %h", {out_index1, out_data1}, exp_q1[0]);
        end
        if (out_ready) void'(exp_q1.pop_front());
      end
    end
  end

  task automatic beat(input logic [W-1:0] d, input logic m, input logic l);
    in_valid = 1'b1; in_data = d; in_mode = m; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0; in_data = '0;
  endtask

  task automatic expect_both(input logic [1:0] idx, input logic [W-1:0] d0, input logic [W-1:0] d1);
    exp_q0.push_back({idx, d0});
    exp_q1.push_back({idx, d1});
  endtask

  task automatic drain(input string name);
    bit done = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (!full0 && !full1) done = 1;
    end
    out_ready = 1'b0;
    check({name, "_timeout"}, 34'(done), 34'd1);
    check({name, "_in_ready"}, {32'd0, in_ready0, in_ready1}, 34'd3);
    check({name, "_q_empty"}, 34'(exp_q0.size() + exp_q1.size()), 34'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 reset_n = 1'b1;
    @(posedge clk); #1;
    check("reset_state", {28'd0, in_ready0, full0, out_valid0, ovf0, in_ready1, full1}, 34'b10_0010);

    // Single pass, overwrite
    beat(32'd5, 0, 0); beat(32'd0, 0, 0); beat(32'd7, 0, 0);
    check("fill_not_full", {32'd0, full0, full1}, 34'd0);
    beat(32'd9, 0, 1);
    check("full_after_last", {30'd0, full0, full1, in_ready0, in_ready1}, 34'b1100);
    expect_both(2'd0, 32'd5, 32'd5); expect_both(2'd1, 32'd0, 32'd0);
    expect_both(2'd2, 32'd7, 32'd7); expect_both(2'd3, 32'd9, 32'd9);
    drain("single");

    // Two-pass accumulate with backpressure at index 1
    beat(32'd1, 0, 0); beat(32'd2, 0, 0); beat(32'd3, 0, 0); beat(32'd4, 0, 0);
    check("between_passes", {32'd0, in_ready0, full0}, 34'b10);
    beat(32'd10, 1, 0); beat(32'd20, 1, 0); beat(32'd30, 1, 0); beat(32'd40, 1, 1);
    expect_both(2'd0, 32'd11, 32'd11); expect_both(2'd1, 32'd22, 32'd22);
    expect_both(2'd2, 32'd33, 32'd33); expect_both(2'd3, 32'd44, 32'd44);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_hold", {out_index0, out_data0}, {2'd1, 32'd22});
    end
    drain("accum");

    // Overflow: positive wrap/saturate in entry 0, negative in entry 1
    beat(32'h7FFF_FFFF, 0, 0); beat(32'h8000_0000, 0, 0); beat(32'd0, 0, 0); beat(32'd0, 0, 0);
    check("ovf_overwrite", {32'd0, ovf0, ovf1}, 34'd0);
    beat(32'd1, 1, 0);
    check("ovf_set", {32'd0, ovf0, ovf1}, 34'b11);
    beat(32'hFFFF_FFFF, 1, 0); beat(32'd0, 1, 0); beat(32'd0, 1, 1);
    expect_both(2'd0, 32'h8000_0000, 32'h7FFF_FFFF);
    expect_both(2'd1, 32'h7FFF_FFFF, 32'h8000_0000);
    expect_both(2'd2, 32'd0, 32'd0); expect_both(2'd3, 32'd0, 32'd0);
    drain("ovf");
    check("ovf_cleared", {32'd0, ovf0, ovf1}, 34'd0);

    // Async reset mid-drain at index 2
    beat(32'd1, 0, 0); beat(32'd2, 0, 0); beat(32'd3, 0, 0); beat(32'd4, 0, 1);
    expect_both(2'd0, 32'd1, 32'd1); expect_both(2'd1, 32'd2, 32'd2);
    expect_both(2'd2, 32'd3, 32'd3); expect_both(2'd3, 32'd4, 32'd4);
    out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_idx", 34'(out_index0), 34'd2);
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_drain", {30'd0, full0, out_valid0, full1, out_valid1}, 34'd0);
    exp_q0.delete(); exp_q1.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    beat(32'd100, 1, 0); beat(32'd200, 1, 0); beat(32'd300, 1, 0); beat(32'd400, 1, 1);
    expect_both(2'd0, 32'd100, 32'd100); expect_both(2'd1, 32'd200, 32'd200);
    expect_both(2'd2, 32'd300, 32'd300); expect_both(2'd3, 32'd400, 32'd400);
    drain("post_reset");

    // Clear together with an accepted beat
    beat(32'd50, 0, 0);
    clear = 1'b1;
    beat(32'd55, 0, 0);
    clear = 1'b0;
    check("after_clear", {32'd0, in_ready0, full0}, 34'b10);
    beat(32'd6, 1, 0); beat(32'd7, 1, 0); beat(32'd8, 1, 0); beat(32'd9, 1, 1);
    expect_both(2'd0, 32'd6, 32'd6); expect_both(2'd1, 32'd7, 32'd7);
    expect_both(2'd2, 32'd8, 32'd8); expect_both(2'd3, 32'd9, 32'd9);
    drain("clear");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accumulator_bank.md
Name: accumulator_bank

Overview:
- Parametrised accumulator buffer that sits below the systolic array's output column.
- Captures a stream of DEPTH partial sums per pass.
- Either overwrites or adds into stored entries, so K-tiled matmuls can sum across multiple passes.
- After the final pass, drains all entries in order over a valid/ready port, then re-arms for the next tile.

Parameters:
- DATA_W, 32, width of input, stored entries and output (two's complement)
- DEPTH, 4, number of entries (>=2); IDX_W = max(1, $clog2(DEPTH))
- SAT, 0, 0 = wrap modulo 2^DATA_W on accumulate; 1 = signed saturation

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear; highest priority after reset
- in_valid  in  1  input entry valid
- in_ready  out  1  bank accepts input (high only in FILL)
- in_data  in  DATA_W  partial sum
- in_mode  in  1  0 = overwrite entry, 1 = add to entry (sampled per accepted beat)
- in_last  in  1  marks the final pass; only meaningful on the beat that writes entry DEPTH-1
- out_valid  out  1  drain data valid
- out_ready  in  1  consumer accepts drain beat
- out_data  out  DATA_W  entry at read pointer
- out_index  out  IDX_W  index of out_data
- full  out  1  high while in DRAIN
- ovf  out  1  sticky: a saturation or wrap occurred during accumulate since the last drain completion or clear

Behaviour:
- Reset (reset_n low, async):
  - all entries = 0; wr_ptr = rd_ptr = 0; state = FILL.
  - full = 0, ovf = 0, out_valid = 0, in_ready = 1 after release.
- clear (sync): same end state as reset; overrides any same-cycle accept or drain handshake.
- States: FILL, DRAIN.
- FILL:
  - in_ready = 1, out_valid = 0.
  - Accept = in_valid & in_ready.
  - Zero-valued data is a normal beat and advances wr_ptr.
  - On accept, mem[wr_ptr] <= in_mode ? mem[wr_ptr] + in_data : in_data. The written value is visible on the next cycle.
  - wr_ptr < DEPTH-1: wr_ptr++.
  - wr_ptr == DEPTH-1 and in_last = 0: wr_ptr wraps to 0 and the bank stays in FILL (next pass).
  - wr_ptr == DEPTH-1 and in_last = 1: wr_ptr -> 0, state -> DRAIN; full = 1 from the next cycle.
- Arithmetic:
  - Signed DATA_W+1-bit sum.
  - SAT=0: keep low DATA_W bits; ovf sets if the sum's sign differs from a correct result (signed overflow).
  - SAT=1: clamp to +2^(DATA_W-1)-1 or -2^(DATA_W-1) and set ovf.
  - Overwrite never sets ovf.
- DRAIN:
  - in_ready = 0 (input ignored), out_valid = 1, out_data = mem[rd_ptr], out_index = rd_ptr.
  - Outputs are stable while out_ready = 0.
  - On out_valid & out_ready: mem[rd_ptr] <= 0 and rd_ptr++.
  - On the handshake at rd_ptr == DEPTH-1: rd_ptr -> 0, state -> FILL, full -> 0, ovf -> 0. in_ready is high the next cycle.
- Drain throughput: one entry per cycle with out_ready held high. Minimum tile time is DEPTH write cycles + DEPTH drain cycles; there is no bubble between drain end and the next FILL beat.
- Reset or clear mid-DRAIN discards the remaining entries. No partial output is re-presented.
- No simultaneous accept and drain: the states are exclusive by construction.

Test Plan:
- Single pass, DEPTH=4, in_mode=0:
  - Stimulus: in_data 5, 0, 7, 9 with in_last=1 on beat 4.
  - Response: full=1 the cycle after beat 4; drain emits (0,5), (1,0), (2,7), (3,9); full=0 and in_ready=1 after the last handshake.
- Two-pass accumulate:
  - Stimulus: pass 1 mode 0 with 1, 2, 3, 4 (in_last=0); pass 2 mode 1 with 10, 20, 30, 40 (in_last=1).
  - Response: drain emits 11, 22, 33, 44; in_ready stays 1 between passes.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles at index 1.
  - Response: out_data and out_index hold at (1, value); no entry is skipped or duplicated.
- Overflow, DATA_W=32:
  - Stimulus: overwrite 0x7FFFFFFF, then add 1.
  - Response with SAT=0: entry = 0x80000000, ovf=1.
  - Response with SAT=1: entry = 0x7FFFFFFF, ovf=1.
  - ovf clears after the drain completes.
- Reset and clear mid-operation:
  - Stimulus: reset_n pulsed low asynchronously mid-DRAIN at index 2.
  - Response: full=0, out_valid=0 immediately; a subsequent drain after a new fill shows only the new values (stale entries read 0).
  - Also: clear asserted together with an accepted in beat leaves the entry 0 and wr_ptr 0.
